pix_frame_stats: RTL and testbench
==================================

# pix_frame_stats

Downstream consumer of the running non-black pixel count. Samples the free-running count at every frame boundary and computes the per-frame delta. Converts the delta into a 0–100 coverage percentage with a multi-cycle sequential divider. Presents the result to the display/readout logic over a valid/ready handshake.

## Interface
Parameters:
- FRAME_PIX, 307200, pixels per frame (640×480); must be 1..2^32-1; divisor for coverage.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_qtd  in  32  free-running colored-pixel count from the upstream counter, wraps mod 2^32.
- vsync  in  1  frame sync; rising edge marks frame boundary.
- stat_ready  in  1  consumer accepts the current report.
- stat_valid  out  1  report available; reset 0.
- frame_pix  out  32  colored pixels in the reported frame; reset 0.
- coverage  out  7  floor(frame_pix*100/FRAME_PIX), saturated at 100; reset 0.
- frame_cnt  out  16  number of accepted reports, wraps 65535→0; reset 0.
- overrun  out  1  sticky; a frame boundary arrived while not IDLE; reset 0; cleared only by rst.
- min_cov  out  7  minimum coverage over accepted reports; reset 100.
- max_cov  out  7  maximum coverage over accepted reports; reset 0.

## Operation
- Edge detect: vsync_d registered; edge = vsync & ~vsync_d. vsync_d resets to 0.
- primed flag (reset 0): the first edge after reset only loads base <= pix_qtd, sets primed, and produces no report.
- base (32 bit, reset 0): on every edge, base <= pix_qtd, in all states.
- FSM states IDLE, DIV, HOLD; reset → IDLE.
  - IDLE: an edge with primed=1 latches delta = pix_qtd - base (mod 2^32, so wrap is correct) into frame_pix.
    - If delta >= FRAME_PIX: coverage <= 100 and go to HOLD.
    - Otherwise load the divider (dividend = delta*100 as 39 bits, divisor = FRAME_PIX) and go to DIV.
  - DIV: restoring divider, one quotient bit per cycle, exactly 39 iterations, then coverage <= quotient[6:0] and go to HOLD.
  - HOLD: stat_valid=1. frame_pix and coverage are stable. On stat_valid & stat_ready: frame_cnt++, update min_cov/max_cov, go to IDLE; stat_valid falls the next cycle.
- Edge while in DIV or HOLD:
  - overrun <= 1.
  - base is updated.
  - The frame is dropped; the in-flight computation and report are unaffected.
- Edge in the same cycle as a HOLD handshake: the frame counts as an overrun (state is not yet IDLE).
- rst mid-DIV or mid-HOLD: aborts to IDLE and clears every output to its reset value, including primed.

## Timing
- Edge detected in cycle E (vsync first sampled high at E-1 edge register).
- Saturated path: stat_valid high from cycle E+1.
- Divide path: DIV during E+1..E+39; stat_valid high from cycle E+40.
- Throughput: one report per frame provided the consumer accepts within the frame period.
- No combinational path from inputs to outputs; stat_ready only affects the next-cycle state.

## Configuration
- PIXSTAT_MINMAX_EN defined: min_cov/max_cov are tracked as described above.
- PIXSTAT_MINMAX_EN undefined: the min_cov/max_cov ports still exist but are tied to constant 0 and the tracking registers are not built.
- All other behaviour is identical in both builds.

## Test plan
- FRAME_PIX=1000: reset, edge with pix_qtd=0, then edge with pix_qtd=500 -> the first edge produces no report; the second gives frame_pix=500, coverage=50, stat_valid at E+40.
- FRAME_PIX=1000: base=0xFFFF_FF00, next edge at pix_qtd=0x0000_0100 -> frame_pix=512, coverage=51 (wrap handled).
- FRAME_PIX=1000: delta=1500 -> coverage=100 with stat_valid at E+1, no DIV cycles.
- Hold stat_ready=0 across a second vsync edge -> overrun=1; the first report stays unchanged; after acceptance, the next frame's delta is measured from the second edge's pix_qtd.
- Three accepted frames with coverage 30, 80, 10 (MINMAX_EN defined) -> min_cov=10, max_cov=80, frame_cnt=3. Without the macro -> both ports read 0.
- Assert rst during DIV -> next cycle stat_valid=0, all outputs at reset values, FSM in IDLE, and the next edge only re-primes.

Source files
------------

// File: rtl/pix_frame_stats.sv
// Per-frame colored-pixel delta and 0-100 coverage with a valid/ready report interface.
// Optional PIXSTAT_MINMAX_EN builds min/max coverage tracking; otherwise min_cov/max_cov read 0.
module pix_frame_stats #(
   parameter int unsigned FRAME_PIX = 307200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pix_qtd,
   input  logic        vsync,
   input  logic        stat_ready,
   output logic        stat_valid,
   output logic [31:0] frame_pix,
   output logic [6:0]  coverage,
   output logic [15:0] frame_cnt,
   output logic        overrun,
   output logic [6:0]  min_cov,
   output logic [6:0]  max_cov
);

   localparam int unsigned PIX_W     = 32;
   localparam int unsigned DIVD_W    = 39;
   localparam int unsigned COV_W     = 7;
   localparam int unsigned CNT_W     = 16;
   localparam int unsigned ITER_W    = 6;
   localparam int unsigned DIV_ITERS = 39;

   localparam logic [PIX_W-1:0] DIVISOR  = PIX_W'(FRAME_PIX);
   localparam logic [COV_W-1:0] COV_FULL = COV_W'(100);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIV,
      ST_HOLD
   } state_e;

   state_e              state_q, state_d;
   logic                vsync_q;
   logic                primed_q, primed_d;
   logic [PIX_W-1:0]    base_q, base_d;
   logic [DIVD_W-1:0]   quot_q, quot_d;
   logic [PIX_W-1:0]    rem_q, rem_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic                valid_q, valid_d;
   logic [PIX_W-1:0]    frame_pix_q, frame_pix_d;
   logic [COV_W-1:0]    cov_q, cov_d;
   logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
   logic                overrun_q, overrun_d;

   logic                edge_c;
   logic                accept_c;
   logic [PIX_W-1:0]    delta_c;
   logic [PIX_W:0]      rem_shift_c;
   logic                sub_ok_c;
   logic [PIX_W-1:0]    rem_next_c;
   logic [DIVD_W-1:0]   quot_next_c;

   assign edge_c   = vsync & ~vsync_q;
   assign accept_c = (state_q == ST_HOLD) & valid_q & stat_ready;
   assign delta_c  = pix_qtd - base_q;

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   assign rem_shift_c = {rem_q, quot_q[DIVD_W-1]};
   assign sub_ok_c    = rem_shift_c >= {1'b0, DIVISOR};
   assign rem_next_c  = sub_ok_c ? PIX_W'(rem_shift_c - {1'b0, DIVISOR}) : rem_shift_c[PIX_W-1:0];
   assign quot_next_c = {quot_q[DIVD_W-2:0], sub_ok_c};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         vsync_q     <= 1'b0;
         primed_q    <= 1'b0;
         base_q      <= '0;
         quot_q      <= '0;
         rem_q       <= '0;
         iter_q      <= '0;
         valid_q     <= 1'b0;
         frame_pix_q <= '0;
         cov_q       <= '0;
         frame_cnt_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         vsync_q     <= vsync;
         primed_q    <= primed_d;
         base_q      <= base_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         iter_q      <= iter_d;
         valid_q     <= valid_d;
         frame_pix_q <= frame_pix_d;
         cov_q       <= cov_d;
         frame_cnt_q <= frame_cnt_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      primed_d    = primed_q;
      base_d      = base_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      iter_d      = iter_q;
      frame_pix_d = frame_pix_q;
      cov_d       = cov_q;
      frame_cnt_d = frame_cnt_q;
      overrun_d   = overrun_q;

      // Every boundary re-bases; boundaries outside IDLE drop their frame.
      if (edge_c) begin
         base_d = pix_qtd;
         if (state_q != ST_IDLE) overrun_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (edge_c) begin
               if (!primed_q) begin
                  primed_d = 1'b1;
               end else begin
                  frame_pix_d = delta_c;
                  if (delta_c >= DIVISOR) begin
                     cov_d   = COV_FULL;
                     state_d = ST_HOLD;
                  end else begin
                     quot_d  = DIVD_W'(delta_c) * DIVD_W'(COV_FULL);
                     rem_d   = '0;
                     iter_d  = '0;
                     state_d = ST_DIV;
                  end
               end
            end
         end
         ST_DIV: begin
            quot_d = quot_next_c;
            rem_d  = rem_next_c;
            iter_d = iter_q + ITER_W'(1);
            if (iter_q == ITER_W'(DIV_ITERS - 1)) begin
               cov_d   = quot_next_c[COV_W-1:0];
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (accept_c) begin
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign valid_d = (state_d == ST_HOLD);

   assign stat_valid = valid_q;
   assign frame_pix  = frame_pix_q;
   assign coverage   = cov_q;
   assign frame_cnt  = frame_cnt_q;
   assign overrun    = overrun_q;

`ifdef PIXSTAT_MINMAX_EN
   logic [COV_W-1:0] min_q, min_d;
   logic [COV_W-1:0] max_q, max_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         min_q <= COV_FULL;
         max_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   // Extremes follow accepted reports only.
   always_comb begin
      min_d = min_q;
      max_d = max_q;
      if (accept_c) begin
         if (cov_q < min_q) min_d = cov_q;
         if (cov_q > max_q) max_d = cov_q;
      end
   end

   assign min_cov = min_q;
   assign max_cov = max_q;
`else
   assign min_cov = '0;
   assign max_cov = '0;
`endif

endmodule

// File: tb/tb_pix_frame_stats.sv
// Directed bench for pix_frame_stats with FRAME_PIX=1000.
module tb_pix_frame_stats;

   localparam int unsigned FRAME_PIX = 1000;
`ifdef PIXSTAT_MINMAX_EN
   localparam logic [6:0] MIN_RST = 7'd100;
   localparam bit         MINMAX  = 1'b1;
`else
   localparam logic [6:0] MIN_RST = 7'd0;
   localparam bit         MINMAX  = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pix_qtd;
   logic        vsync;
   logic        stat_ready;
   logic        stat_valid;
   logic [31:0] frame_pix;
   logic [6:0]  coverage;
   logic [15:0] frame_cnt;
   logic        overrun;
   logic [6:0]  min_cov;
   logic [6:0]  max_cov;

   int n_vec = 0;
   int n_err = 0;
   logic [15:0] exp_cnt = '0;

   pix_frame_stats #(.FRAME_PIX(FRAME_PIX)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_qtd    (pix_qtd),
      .vsync      (vsync),
      .stat_ready (stat_ready),
      .stat_valid (stat_valid),
      .frame_pix  (frame_pix),
      .coverage   (coverage),
      .frame_cnt  (frame_cnt),
      .overrun    (overrun),
      .min_cov    (min_cov),
      .max_cov    (max_cov)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic [31:0] qtd);
      pix_qtd = qtd;
      vsync   = 1'b1;
      tick();
      vsync   = 1'b0;
   endtask

   task automatic accept();
      stat_ready = 1'b1;
      tick();
      stat_ready = 1'b0;
      exp_cnt++;
      chk("valid_after_accept", 32'(stat_valid), 32'd0);
      chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
   endtask

   // Edge, latency check, value check, optional acceptance.
   task automatic report(input string tag, input logic [31:0] qtd, input logic [31:0] exp_pix,
                         input logic [6:0] exp_cov, input bit sat, input bit acc);
      pulse(qtd);
      if (!sat) begin
         repeat (38) tick();
         chk({tag, "_valid_early"}, 32'(stat_valid), 32'd0);
         tick();
      end
      chk({tag, "_valid"}, 32'(stat_valid), 32'd1);
      chk({tag, "_frame_pix"}, frame_pix, exp_pix);
      chk({tag, "_coverage"}, 32'(coverage), 32'(exp_cov));
      if (acc) accept();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, 32'(stat_valid), 32'd0);
      chk({tag, "_frame_pix"}, frame_pix, 32'd0);
      chk({tag, "_coverage"}, 32'(coverage), 32'd0);
      chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
      chk({tag, "_overrun"}, 32'(overrun), 32'd0);
      chk({tag, "_min_cov"}, 32'(min_cov), 32'(MIN_RST));
      chk({tag, "_max_cov"}, 32'(max_cov), 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      pix_qtd    = '0;
      vsync      = 1'b0;
      stat_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk_reset_outputs("reset");

      // First edge only primes.
      pulse(32'd0);
      repeat (45) tick();
      chk("prime_no_report", 32'(stat_valid), 32'd0);

      report("half", 32'd500, 32'd500, 7'd50, 1'b0, 1'b0);
      repeat (3) tick();
      chk("half_hold_valid", 32'(stat_valid), 32'd1);
      chk("half_hold_cov", 32'(coverage), 32'd50);
      accept();

      // Saturated frame sets base near the top, then a wrapping delta.
      report("big", 32'hFFFF_FF00, 32'hFFFF_FD0C, 7'd100, 1'b1, 1'b1);
      report("wrap", 32'h0000_0100, 32'd512, 7'd51, 1'b0, 1'b1);
      report("sat", 32'd1756, 32'd1500, 7'd100, 1'b1, 1'b1);
      chk("no_overrun_yet", 32'(overrun), 32'd0);

      // Boundary while the report is held: dropped frame, report untouched.
      report("ovr", 32'd2006, 32'd250, 7'd25, 1'b0, 1'b0);
      pulse(32'd2706);
      chk("overrun_set", 32'(overrun), 32'd1);
      chk("ovr_held_valid", 32'(stat_valid), 32'd1);
      chk("ovr_held_pix", frame_pix, 32'd250);
      chk("ovr_held_cov", 32'(coverage), 32'd25);
      accept();
      report("rebase", 32'd2806, 32'd100, 7'd10, 1'b0, 1'b1);
      chk("overrun_sticky", 32'(overrun), 32'd1);
      chk("mm_min_pre", 32'(min_cov), MINMAX ? 32'd10 : 32'd0);
      chk("mm_max_pre", 32'(max_cov), MINMAX ? 32'd100 : 32'd0);

      // Reset in the middle of a division.
      pulse(32'd3106);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_cnt = '0;
      chk_reset_outputs("mid_div_rst");
      tick();
      chk("post_rst_idle", 32'(stat_valid), 32'd0);
      pulse(32'd5000);
      repeat (45) tick();
      chk("reprime_no_report", 32'(stat_valid), 32'd0);

      report("f30", 32'd5300, 32'd300, 7'd30, 1'b0, 1'b1);
      report("f80", 32'd6100, 32'd800, 7'd80, 1'b0, 1'b1);
      report("f10", 32'd6200, 32'd100, 7'd10, 1'b0, 1'b1);
      chk("final_frame_cnt", 32'(frame_cnt), 32'd3);
      chk("final_min_cov", 32'(min_cov), MINMAX ? 32'd10 : 32'd0);
      chk("final_max_cov", 32'(max_cov), MINMAX ? 32'd80 : 32'd0);
      chk("final_overrun", 32'(overrun), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
